// File: rtl/simple_uart_rx.sv
// simple_uart_rx: Wishbone-polled 8N1 UART receiver with RX FIFO, sticky error flags and a level IRQ.
module simple_uart_rx #(
  parameter logic [31:0] WB_ADDR    = 32'h40000110,
  parameter int          CLK_FREQ   = 10000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  input  logic        i_uart_rx,
  output logic        o_rx_irq
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nx;
  logic            rx_m, rx_s, rx_p, fall;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tick, shift_en, stop_ok, stop_bad;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            empty, full, push, pop, ovr_set;
  logic            overrun, frame_err;
  logic            hit_dat, hit_st, acc, wr_st;
  logic [31:0]     status;
  logic            unused;

  assign unused = ^{i_wb_dat[31:3], i_wb_dat[0]};

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {rx_m, rx_s, rx_p} <= 3'b111;
    else          {rx_m, rx_s, rx_p} <= {i_uart_rx, rx_m, rx_s};

  assign fall = rx_p & ~rx_s;
  assign tick = (state == START) ? (cnt == HALF_END) : (cnt == BIT_END);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = fall ? START : IDLE;
      START: state_nx = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:  state_nx = (tick && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_nx = tick ? IDLE : STOP;
    endcase
  end

  always_comb begin
    shift_en = (state == DATA) & tick;
    stop_ok  = (state == STOP) & tick & rx_s;
    stop_bad = (state == STOP) & tick & ~rx_s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt     <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      bit_idx <= (state != DATA) ? 3'd0 : bit_idx + 3'(shift_en);
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end

  assign hit_dat = i_wb_adr == WB_ADDR;
  assign hit_st  = i_wb_adr == WB_ADDR + 32'd4;
  assign acc     = i_wb_stb & (hit_dat | hit_st) & ~o_wb_ack;
  assign wr_st   = acc & i_wb_we & hit_st;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign pop     = acc & ~i_wb_we & hit_dat & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = stop_ok & (~full | pop);
  assign ovr_set = stop_ok & full & ~pop;

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= shift;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count + (AW+1)'(push) - (AW+1)'(pop);
      overrun   <= ovr_set | (overrun & ~(wr_st & i_wb_dat[1]));
      frame_err <= stop_bad | (frame_err & ~(wr_st & i_wb_dat[2]));
    end

  assign status = {16'b0, 8'(count), 5'b0, frame_err, overrun, ~empty};

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= acc;
      if (acc && !i_wb_we) o_wb_dat <= hit_dat ? (empty ? 32'd0 : {23'b0, 1'b1, mem[rd_ptr]}) : status;
    end

  assign o_rx_irq = ~empty | overrun | frame_err;
endmodule

// File: tb/tb_simple_uart_rx.sv
// tb_simple_uart_rx: directed plus randomized frames checked against a queue-based receiver model.
module tb_simple_uart_rx;
  localparam logic [31:0] DAT = 32'h40000110;
  localparam logic [31:0] ST  = 32'h40000114;
  localparam int BIT_CLKS = 10000000 / 115200;

  logic        clk = 0, rst_n = 0, we = 0, stb = 0, rx = 1;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic        ack, irq;

  int n_assert = 0, n_fail = 0;
  logic [7:0] q[$];
  logic ovr = 0, fe = 0;

  simple_uart_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_we(we),
    .i_wb_stb(stb), .o_wb_dat(rdat), .o_wb_ack(ack), .i_uart_rx(rx), .o_rx_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'b0, 8'(q.size()), 5'b0, fe, ovr, q.size() != 0};
  endfunction

  function automatic logic [31:0] exp_read();
    logic [7:0] b;
    if (q.size() == 0) return 32'd0;
    b = q.pop_front();
    return {23'b0, 1'b1, b};
  endfunction

  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] r, output logic acked);
    @(negedge clk);
    adr = a; we = w; wdat = d; stb = 1; acked = 0; r = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(negedge clk);
      if (ack) begin acked = 1; r = rdat; end
    end
    stb = 0; we = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic k;
    wb_cycle(a, 0, 0, r, k);
    check({tag, "_ack"}, {31'b0, k}, 32'd1);
    check(tag, r, exp);
  endtask

  task automatic rd_status(input string tag);
    rd(tag, ST, exp_status());
  endtask

  task automatic rd_data(input string tag);
    rd(tag, DAT, exp_read());
  endtask

  task automatic w1c(input string tag, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    wb_cycle(ST, 1, d, r, k);
    check({tag, "_ack"}, {31'b0, k}, 32'd1);
    if (d[1]) ovr = 0;
    if (d[2]) fe = 0;
  endtask

  task automatic line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    line(0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line(b[i], BIT_CLKS);
    line(stop, BIT_CLKS);
    line(1, 6);
    if (!stop) fe = 1;
    else if (q.size() == 8) ovr = 1;
    else q.push_back(b);
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    check(tag, {31'b0, irq}, {31'b0, (q.size() != 0) | ovr | fe});
  endtask

  initial begin
    logic [31:0] r;
    logic k;
    logic [7:0] b;
    logic s;
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_irq("reset_irq");
    wb_cycle(ST, 0, 0, r, k);
    check("reset_status_ack", {31'b0, k}, 32'd1);
    check("reset_status", r, 32'h0);
    @(negedge clk);
    check("ack_pulse", {31'b0, ack}, 32'd0);

    wb_cycle(DAT + 32'd8, 0, 0, r, k);
    check("bad_addr_noack", {31'b0, k}, 32'd0);

    send(8'hA5, 1);
    rd("a5_status", ST, 32'h00000101);
    check_irq("a5_irq");
    rd("a5_read", DAT, 32'h000001A5);
    void'(q.pop_front());
    rd("a5_status_after", ST, 32'h0);
    check_irq("a5_irq_after");

    line(0, 20);
    line(1, 3 * BIT_CLKS);
    rd("glitch_status", ST, 32'h0);

    send(8'h3C, 0);
    rd("frame_status", ST, 32'h00000004);
    rd_data("frame_empty_read");
    w1c("frame_clr", 32'h4);
    rd("frame_cleared", ST, 32'h0);

    for (int i = 1; i <= 9; i++) send(8'(i), 1);
    rd("ovr_status", ST, 32'h00000803);
    for (int i = 1; i <= 8; i++) begin
      rd("ovr_read", DAT, 32'h100 + 32'(i));
      void'(q.pop_front());
    end
    rd("ovr_read_empty", DAT, 32'h0);
    rd("ovr_sticky", ST, 32'h00000002);
    wb_cycle(DAT, 1, 32'hFF, r, k);
    check("dat_write_ack", {31'b0, k}, 32'd1);
    rd_status("dat_write_noeffect");
    w1c("ovr_clr", 32'h2);
    rd("ovr_cleared", ST, 32'h0);

    line(0, 20 * BIT_CLKS);
    line(1, 2 * BIT_CLKS);
    fe = 1;
    rd("break_status", ST, 32'h00000004);
    w1c("break_clr", 32'h4);

    send(8'h66, 1);
    send(8'h77, 0);
    line(0, BIT_CLKS);
    for (int i = 0; i < 4; i++) line(1'b1, BIT_CLKS);
    line(0, 40);
    rst_n = 0;
    repeat (5) @(negedge clk);
    rx = 1; rst_n = 1;
    q.delete(); ovr = 0; fe = 0;
    line(1, 2 * BIT_CLKS);
    rd("midreset_status", ST, 32'h0);
    send(8'h5A, 1);
    rd("midreset_read", DAT, 32'h0000015A);
    void'(q.pop_front());
    rd("midreset_after", ST, 32'h0);

    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 3) != 0;
      send(b, s);
      check_irq("rand_irq");
      if ($urandom_range(0, 1) == 1) rd_data("rand_read");
      rd_status("rand_status");
      if ($urandom_range(0, 3) == 0) w1c("rand_clr", $urandom & 32'h6);
    end
    while (q.size() != 0) rd_data("drain_read");
    rd_data("drain_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_uart_rx.md
Name: simple_uart_rx

Overview:
Wishbone-attached UART receiver, 8N1, the serial-line counterpart of the TX-only UART on the same peripheral bus. It samples the asynchronous RX pin, deserialises bytes and buffers them in a small FIFO. The CPU polls a status register and pops bytes with bus reads. It also provides a level interrupt for pending data or errors.

Parameters:
WB_ADDR, 32'h40000110, base address; RX data register at WB_ADDR, status register at WB_ADDR+4
CLK_FREQ, 10000000, i_clk frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 86 at defaults); HALF_BIT = CLKS_PER_BIT/2 (43)
FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..128

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_wb_adr  input  32  Wishbone address
i_wb_dat  input  32  Wishbone write data
i_wb_we  input  1  write enable
i_wb_stb  input  1  strobe
o_wb_dat  output  32  read data, registered
o_wb_ack  output  1  acknowledge, registered
i_uart_rx  input  1  asynchronous serial input, idle high
o_rx_irq  output  1  level: rx_avail | overrun | frame_err

Behaviour:
- Reset (async assert, sync deassert internally not required): o_wb_dat=0, o_wb_ack=0, FIFO empty, overrun=0, frame_err=0, both sync flops=1, FSM=IDLE, counters=0. o_rx_irq=0.
- Input sync: two flops on i_uart_rx; all RX logic uses the second flop (rx_s). Falling edge = prior rx_s 1, current rx_s 0.
- FSM:
  - IDLE: on falling edge go START, cnt=0.
  - START: cnt increments each cycle; at cnt==HALF_BIT-1 sample rx_s. If 1: false start, go IDLE. If 0: go DATA, cnt=0, bit_idx=0.
  - DATA: at cnt==CLKS_PER_BIT-1 sample rx_s into shift register, LSB first, cnt=0, bit_idx++. After 8th sample go STOP.
  - STOP: at cnt==CLKS_PER_BIT-1 sample. If 1, push byte: if FIFO full and no pop that same cycle, drop byte and set overrun. If 0, discard byte and set frame_err. Either way go IDLE.
- IDLE requires a new falling edge, so a held-low break line produces exactly one framing error.
- Bus access is acked only for matching addresses; other addresses get no ack. Ack rule: o_wb_ack <= i_wb_stb & match & ~o_wb_ack, giving a one-cycle pulse per access. An action takes effect in the cycle the ack is generated.
- Read WB_ADDR: o_wb_dat = {23'b0, valid, data[7:0]}, where valid = FIFO non-empty. If non-empty, pop one entry. If empty, return 0 with no pop.
- Read WB_ADDR+4: o_wb_dat = {16'b0, count[7:0] zero-extended, 5'b0, frame_err, overrun, rx_avail}. rx_avail = count != 0.
- Write WB_ADDR+4: W1C; bit1 clears overrun, bit2 clears frame_err. A set event in the same cycle wins.
- Write WB_ADDR: acked, no effect.
- Simultaneous push and pop: both take effect, count unchanged. Full FIFO with simultaneous pop and push: push accepted, no overrun.
- FIFO pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- o_wb_dat holds its last value between reads.
- Reset mid-frame: partial byte discarded. After release, wait for a fresh falling edge.

Test Plan:
- Reset then status read -> o_wb_ack pulses one cycle, o_wb_dat=0x00000000, o_rx_irq=0.
- Drive 0xA5 at 86 clk/bit -> status=0x00000101, irq=1. RX read=0x000001A5. Status then 0x00000000, irq=0.
- 20-cycle low glitch on idle line -> no push, status stays 0x00000000.
- Send 0x3C with stop bit 0 -> status=0x00000004, FIFO empty. Write 0x4 to status -> status 0x00000000.
- Send 9 bytes 0x01..0x09 with no reads -> status=0x00000803. Eight reads return 0x101..0x108, ninth read returns 0x00000000. Overrun stays set until W1C.
- Assert i_rst_n low during data bit 4 of a frame, release, then send 0x5A -> FIFO holds only 0x5A (read=0x0000015A), no error flags.
